// File: rtl/i2s_tx.sv
// Philips I2S transmitter: serialises one mono sample per frame onto both
// channel slots, with a one-entry holding register pacing the upstream source.
module i2s_tx #(
  parameter int width_p      = 24,
  parameter int bclk_div_p   = 4,
  parameter int slot_width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               bclk_o,
  output logic               lrclk_o,
  output logic               sdata_o,
  output logic               underrun_o
);

  localparam int bw_lp = $clog2(bclk_div_p);
  localparam int pw_lp = $clog2(2 * slot_width_p);
  localparam int iw_lp = $clog2(width_p + 1);

  logic [bw_lp-1:0]   bcnt_r, bcnt_n;
  logic [pw_lp-1:0]   pos_r, pos_n, b_n;
  logic [width_p-1:0] hold_r, frame_r, frame_n;
  logic               full_r, full_n;
  logic               fall, wrap, load, accept;
  logic               bclk_n, lrclk_n, sdata_n, underrun_n;
  logic [iw_lp-1:0]   idx;

  assign ready_o = ~full_r;
  assign accept  = valid_i & ~full_r;

  // Outputs are registered from the next-state values so each pin reflects
  // the divider/bit position it belongs to without a cycle of skew.
  always_comb begin
    fall       = (bcnt_r == bw_lp'(bclk_div_p - 1));
    wrap       = (pos_r == pw_lp'(2 * slot_width_p - 1));
    load       = fall & wrap;
    bcnt_n     = fall ? '0 : bcnt_r + bw_lp'(1);
    pos_n      = pos_r;
    if (fall) pos_n = wrap ? '0 : pos_r + pw_lp'(1);
    frame_n    = frame_r;
    if (load) frame_n = full_r ? hold_r : '0;
    // A frame load only empties the register if it actually consumed a sample;
    // an accept colliding with an empty-register load still sets full.
    full_n     = full_r;
    if (load && full_r) full_n = 1'b0;
    else if (accept)    full_n = 1'b1;
    underrun_n = load & ~full_r;
    bclk_n     = (bcnt_n >= bw_lp'(bclk_div_p / 2));
    lrclk_n    = (pos_n >= pw_lp'(slot_width_p));
    b_n        = lrclk_n ? pos_n - pw_lp'(slot_width_p) : pos_n;
    idx        = iw_lp'(width_p) - iw_lp'(b_n);
    sdata_n    = 1'b0;
    if (b_n != '0 && b_n <= pw_lp'(width_p)) sdata_n = frame_n[idx];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bcnt_r     <= '0;
      pos_r      <= '0;
      frame_r    <= '0;
      hold_r     <= '0;
      full_r     <= 1'b0;
      bclk_o     <= 1'b0;
      lrclk_o    <= 1'b0;
      sdata_o    <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      bcnt_r     <= bcnt_n;
      pos_r      <= pos_n;
      frame_r    <= frame_n;
      full_r     <= full_n;
      if (accept) hold_r <= data_i;
      bclk_o     <= bclk_n;
      lrclk_o    <= lrclk_n;
      sdata_o    <= sdata_n;
      underrun_o <= underrun_n;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: cycle-indexed output vectors, an independent
// I2S receiver decoding the serial stream, and hand sequences for corner cases.
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [23:0] data_i = '0;
  logic        bclk_o, lrclk_o, sdata_o, underrun_o;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int underrunSeen = 0;
  int acceptCount = 0;

  typedef struct {
    int   k;
    logic bclk;
    logic lr;
    logic sd;
    logic un;
    logic rdy;
  } vec_t;

  vec_t vecs[16];

  logic [23:0] words[$];
  logic [23:0] expWords[$];
  logic [23:0] shiftReg = '0;
  int          bitIdx = 0;
  logic        lastLr = 1'b1;
  logic        prevBclk = 1'b0;

  i2s_tx dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_i     (data_i),
    .bclk_o     (bclk_o),
    .lrclk_o    (lrclk_o),
    .sdata_o    (sdata_o),
    .underrun_o (underrun_o)
  );

  always #5 clk = ~clk;

  // Independent receiver: a new slot starts at the first BCLK rise after an
  // LRCLK change; bits 1..24 of the slot form the word, MSB first.
  always @(negedge clk) begin
    if (reset_i) begin
      bitIdx   = 0;
      lastLr   = 1'b1;
      shiftReg = '0;
    end else if (bclk_o && !prevBclk) begin
      if (lrclk_o != lastLr) begin
        bitIdx = 0;
        lastLr = lrclk_o;
      end else begin
        bitIdx++;
      end
      if (bitIdx >= 1 && bitIdx <= 24) shiftReg = {shiftReg[22:0], sdata_o};
      if (bitIdx == 24) words.push_back(shiftReg);
    end
    prevBclk = bclk_o;
  end

  task automatic applyStimulus();
    @(negedge clk);
    cyc++;
    if (underrun_o) underrunSeen++;
  endtask

  task automatic waitTo(input int k);
    while (cyc < k) applyStimulus();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got 'h%0h, expected 'h%0h", name, cyc, actual, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " bclk"}, 32'(bclk_o), 32'd0);
    checkOutput({tag, " lrclk"}, 32'(lrclk_o), 32'd0);
    checkOutput({tag, " sdata"}, 32'(sdata_o), 32'd0);
    checkOutput({tag, " underrun"}, 32'(underrun_o), 32'd0);
    checkOutput({tag, " ready"}, 32'(ready_o), 32'd1);
  endtask

  task automatic checkWords(input string tag);
    checkOutput({tag, " word count"}, 32'(words.size()), 32'(expWords.size()));
    for (int i = 0; i < expWords.size() && i < words.size(); i++)
      checkOutput($sformatf("%s word %0d", tag, i), 32'(words[i]), 32'(expWords[i]));
  endtask

  initial begin
    logic willAccept;

    vecs[0]  = '{1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{255, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{256, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{260, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{264, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{352, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{356, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{383, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{384, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{388, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{480, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{511, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{512, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{513, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{516, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    expWords = '{24'h000000, 24'h000000, 24'h800001, 24'h800001,
                 24'h000000, 24'h000000, 24'h000100, 24'h000100,
                 24'h000101, 24'h000101, 24'h000102, 24'h000102,
                 24'h000103, 24'h000103, 24'h000000, 24'h000000,
                 24'h000000, 24'h000000, 24'h123456, 24'h123456,
                 24'h000000};

    repeat (3) applyStimulus();
    checkResetOutputs("reset");

    reset_i = 1'b0;
    cyc     = 0;
    valid_i = 1'b1;
    data_i  = 24'h800001;
    for (int i = 0; i < 16; i++) begin
      waitTo(vecs[i].k);
      valid_i = 1'b0;
      checkOutput($sformatf("vec%0d bclk", i), 32'(bclk_o), 32'(vecs[i].bclk));
      checkOutput($sformatf("vec%0d lrclk", i), 32'(lrclk_o), 32'(vecs[i].lr));
      checkOutput($sformatf("vec%0d sdata", i), 32'(sdata_o), 32'(vecs[i].sd));
      checkOutput($sformatf("vec%0d underrun", i), 32'(underrun_o), 32'(vecs[i].un));
      checkOutput($sformatf("vec%0d ready", i), 32'(ready_o), 32'(vecs[i].rdy));
    end

    // Backpressure: valid held high, data advances only once a word is taken.
    underrunSeen = 0;
    data_i = 24'h000100;
    while (cyc < 1290) begin
      valid_i    = 1'b1;
      willAccept = valid_i & ready_o;
      applyStimulus();
      if (willAccept) begin
        acceptCount++;
        data_i = data_i + 24'd1;
      end
    end
    valid_i = 1'b0;
    checkOutput("accepts per frame", 32'(acceptCount), 32'd4);

    waitTo(1791);
    checkOutput("no underrun while fed", 32'(underrunSeen), 32'd0);
    applyStimulus();
    checkOutput("underrun pulse", 32'(underrun_o), 32'd1);
    applyStimulus();
    checkOutput("underrun one cycle", 32'(underrun_o), 32'd0);

    // Collision: sample arrives in the very cycle of an empty frame load.
    waitTo(2047);
    valid_i = 1'b1;
    data_i  = 24'h123456;
    applyStimulus();
    valid_i = 1'b0;
    checkOutput("collision underrun", 32'(underrun_o), 32'd1);
    checkOutput("collision ready", 32'(ready_o), 32'd0);

    waitTo(2560);
    checkOutput("empty load underrun", 32'(underrun_o), 32'd1);
    valid_i = 1'b1;
    data_i  = 24'h0ABCDE;
    applyStimulus();
    valid_i = 1'b0;
    checkOutput("held before reset", 32'(ready_o), 32'd0);

    waitTo(2720);
    checkWords("stream");

    // Mid-frame reset at pos 40 with a sample held.
    reset_i = 1'b1;
    applyStimulus();
    applyStimulus();
    checkResetOutputs("midreset");
    reset_i = 1'b0;
    cyc     = 0;
    words.delete();
    expWords = '{24'h000000, 24'h000000, 24'h000000, 24'h000000};

    waitTo(256);
    checkOutput("post-reset underrun", 32'(underrun_o), 32'd1);
    checkOutput("post-reset ready", 32'(ready_o), 32'd1);
    waitTo(500);
    checkWords("post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
